// File: rtl/dft_pkg.sv
// Shared constants, FSM encoding and helpers for the window-DFT twiddle path.
package dft_pkg;

  // Quadrant encoding of the top two phase bits
  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // DFT length N = 2^log2n
  function automatic int unsigned dft_n(input int unsigned log2n);
    return 32'd1 << log2n;
  endfunction

  // Quarter-wave length Q = N/4
  function automatic int unsigned dft_q(input int unsigned log2n);
    return dft_n(log2n) >> 2;
  endfunction

  // Negate a w-bit signed value held sign-extended in 32 bits; the most
  // negative code saturates to the most positive one.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x,
                                                 input int unsigned       w);
    logic signed [31:0] lo;
    lo = -(32'sd1 <<< (w - 32'd1));
    if (x == lo) return ~lo;
    return -x;
  endfunction

endpackage

// File: rtl/dft_qw_rom.sv
// Dual-read-port registered quarter-wave sine ROM (s[j] = sin(2*pi*j/N)).
module dft_qw_rom
  import dft_pkg::*;
#(
  parameter int unsigned LOG2N   = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 5,
  parameter int unsigned AW      = 3,
  parameter string       QW_FILE = "dft_twiddle_qw_16.mem"
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic [AW-1:0]     i_addr_a,
  input  logic [AW-1:0]     i_addr_b,
  output logic [DATA_W-1:0] o_data_a,
  output logic [DATA_W-1:0] o_data_b
);

  localparam real PI = 3.14159265358979323846;

  typedef logic [DATA_W-1:0] qw_tbl_t [DEPTH];

  logic [DATA_W-1:0] r_data_a;
  logic [DATA_W-1:0] r_data_b;

  // Round-half-away-from-zero, saturated quarter-wave entry
  function automatic logic [DATA_W-1:0] qw_entry(input int unsigned j);
    real    v;
    longint iv;
    longint mx;
    v  = $sin(2.0 * PI * real'(j) / real'(dft_n(LOG2N))) * (2.0 ** (DATA_W - 1));
    iv = longint'($floor(v + 0.5));
    mx = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    if (iv > mx) iv = mx;
    return DATA_W'(iv);
  endfunction

  // Full quarter-wave table
  function automatic qw_tbl_t qw_table();
    qw_tbl_t t;
    for (int unsigned j = 0; j < DEPTH; j++) t[j] = qw_entry(j);
    return t;
  endfunction

  localparam qw_tbl_t QW_TBL = qw_table();

  // Registered reads, held while the pipeline is stalled
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_data_a <= QW_TBL[i_addr_a];
      r_data_b <= QW_TBL[i_addr_b];
    end
  end

  assign o_data_a = r_data_a;
  assign o_data_b = r_data_b;

endmodule

// File: rtl/dft_twiddle_gen.sv
// Twiddle streamer: emits w[(k*n) mod N], n = 0..N-1, over valid/ready.
module dft_twiddle_gen
  import dft_pkg::*;
#(
  parameter int unsigned LOG2N   = 4,
  parameter int unsigned DATA_W  = 16,
  parameter string       QW_FILE = "dft_twiddle_qw_16.mem"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LOG2N-1:0]  bin,
  input  logic              inverse,
  output logic              busy,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [LOG2N-1:0]  out_idx,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned N  = dft_n(LOG2N);
  localparam int unsigned Q  = dft_q(LOG2N);
  localparam int unsigned AW = LOG2N - 1;
  localparam int unsigned RW = LOG2N - 2;

  state_e            r_state, w_state_nxt;
  logic              r_busy;
  logic [LOG2N-1:0]  r_k, r_p, r_n;
  logic              r_inv;
  logic              w_en, w_load, w_issue;

  logic [1:0]        w_quad;
  logic [RW-1:0]     w_r;
  logic [AW-1:0]     w_addr_lo, w_addr_hi, w_addr_re, w_addr_im;
  logic [DATA_W-1:0] w_rom_re, w_rom_im;

  logic              r_s1_valid, r_s1_last;
  logic [1:0]        r_s1_quad;
  logic [LOG2N-1:0]  r_s1_idx;

  logic              w_re_neg, w_im_neg;
  logic [DATA_W-1:0] w_re, w_im;

  logic              r_out_valid, r_out_last;
  logic [DATA_W-1:0] r_out_re, r_out_im;
  logic [LOG2N-1:0]  r_out_idx;

  assign w_en = !r_out_valid || out_ready;

  // Quarter-wave addressing: s[r] and s[Q-r], swapped on odd quadrants
  assign w_quad    = r_p[LOG2N-1 -: 2];
  assign w_r       = r_p[RW-1:0];
  assign w_addr_lo = AW'(w_r);
  assign w_addr_hi = AW'(Q) - AW'(w_r);
  assign w_addr_re = w_quad[0] ? w_addr_lo : w_addr_hi;
  assign w_addr_im = w_quad[0] ? w_addr_hi : w_addr_lo;

  dft_qw_rom #(
    .LOG2N  (LOG2N),
    .DATA_W (DATA_W),
    .DEPTH  (Q + 1),
    .AW     (AW),
    .QW_FILE(QW_FILE)
  ) u_rom (
    .i_clk   (clk),
    .i_en    (w_en),
    .i_addr_a(w_addr_re),
    .i_addr_b(w_addr_im),
    .o_data_a(w_rom_re),
    .o_data_b(w_rom_im)
  );

  // Sweep control: next state and S0 issue/load strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_issue     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_en) begin
          w_issue = 1'b1;
          if (r_n == LOG2N'(N - 1)) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_out_valid && out_ready && r_out_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and S0 phase/index accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_k     <= '0;
      r_inv   <= 1'b0;
      r_p     <= '0;
      r_n     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (w_load) begin
        r_k   <= bin;
        r_inv <= inverse;
        r_p   <= '0;
        r_n   <= '0;
      end else if (w_issue) begin
        r_p <= r_p + r_k;
        r_n <= r_n + LOG2N'(1);
      end
    end
  end

  // S1 sideband travelling alongside the ROM read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_quad  <= '0;
      r_s1_idx   <= '0;
    end else if (w_en) begin
      r_s1_valid <= w_issue;
      r_s1_last  <= (r_n == LOG2N'(N - 1));
      r_s1_quad  <= w_quad;
      r_s1_idx   <= r_n;
    end
  end

  // Quadrant signs; the inverse mode flips the imaginary sign once more
  assign w_re_neg = (r_s1_quad == QUAD_1) || (r_s1_quad == QUAD_2);
  assign w_im_neg = ((r_s1_quad == QUAD_2) || (r_s1_quad == QUAD_3)) ^ r_inv;
  assign w_re = w_re_neg ? DATA_W'(sat_neg(32'(signed'(w_rom_re)), DATA_W)) : w_rom_re;
  assign w_im = w_im_neg ? DATA_W'(sat_neg(32'(signed'(w_rom_im)), DATA_W)) : w_rom_im;

  // S2 output registers, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_idx   <= '0;
    end else if (w_en) begin
      r_out_valid <= r_s1_valid;
      r_out_last  <= r_s1_valid && r_s1_last;
      if (r_s1_valid) begin
        r_out_re  <= w_re;
        r_out_im  <= w_im;
        r_out_idx <= r_s1_idx;
      end
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;
  assign out_idx   = r_out_idx;

endmodule

// File: tb/tb_dft_twiddle_gen.sv
// Directed bench for dft_twiddle_gen at N=16, DATA_W=16.
module tb_dft_twiddle_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  bin;
  logic        inverse;
  logic        busy;
  logic [15:0] out_re;
  logic [15:0] out_im;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  dft_twiddle_gen #(
    .LOG2N  (4),
    .DATA_W (16),
    .QW_FILE("")
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .inverse  (inverse),
    .busy     (busy),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_idx  (out_idx),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Hand-computed w_i = exp(+j*2*pi*i/16) * 32768, rounded, saturated
  int tr [16] = '{ 32767,  30274,  23170,  12540,      0, -12540, -23170, -30274,
                  -32767, -30274, -23170, -12540,      0,  12540,  23170,  30274};
  int ti [16] = '{     0,  12540,  23170,  30274,  32767,  30274,  23170,  12540,
                       0, -12540, -23170, -30274, -32767, -30274, -23170, -12540};

  int n_chk = 0;
  int n_err = 0;
  int first_c, last_c, fall_c, n_beats;
  int got_re [16];
  int got_im [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input int k, input bit inv);
    out_ready = 1'b1;
    bin       = 4'(k);
    inverse   = inv;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Follows one sweep from the cycle after start acceptance; checks every
  // visible beat against the table. abort_at >= 0 returns on that beat.
  task automatic collect(input string tag, input int k, input bit inv,
                         input bit rnd, input bit spam, input int abort_at);
    int  e;
    int  c;
    int  p;
    bit  done;
    e = 0; c = 1; done = 1'b0;
    first_c = -1; last_c = -1; fall_c = -1;
    check({tag, "_busy_rise"}, int'(busy), 1);
    while (c < 300) begin
      if (!busy && e == 16) begin
        fall_c = c;
        done   = 1'b1;
        break;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (spam && busy) begin
        start   = 1'b1;
        bin     = 4'd7;
        inverse = ~inv;
      end
      if (out_valid) begin
        if (first_c < 0) first_c = c;
        p = (k * e) % 16;
        check({tag, "_idx"},  int'(out_idx), e);
        check({tag, "_re"},   int'($signed(out_re)), tr[p]);
        check({tag, "_im"},   int'($signed(out_im)), inv ? -ti[p] : ti[p]);
        check({tag, "_last"}, int'(out_last), (e == 15) ? 1 : 0);
        if (abort_at >= 0 && e == abort_at) begin
          done = 1'b1;
          break;
        end
        if (out_ready && e < 16) begin
          got_re[e] = int'($signed(out_re));
          got_im[e] = int'($signed(out_im));
          if (e == 15) last_c = c;
          e++;
        end
      end
      tick();
      c++;
    end
    if (spam) start = 1'b0;
    if (!done) check({tag, "_timeout"}, 0, 1);
    n_beats = e;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bin = '0; inverse = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_busy",  int'(busy), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_last",  int'(out_last), 0);
    check("rst_idx",   int'(out_idx), 0);
    check("rst_re",    int'(out_re), 0);
    check("rst_im",    int'(out_im), 0);
    rst = 1'b0;
    tick();

    // bin=1 forward, full-rate consumer
    issue_start(1, 1'b0);
    collect("b1", 1, 1'b0, 1'b0, 1'b0, -1);
    check("b1_first_valid", first_c, 3);
    check("b1_last_beat",   last_c, 18);
    check("b1_busy_fall",   fall_c, 19);
    check("b1_beats",       n_beats, 16);
    check("b1_n0_re", got_re[0], 32767); check("b1_n0_im", got_im[0], 0);
    check("b1_n1_re", got_re[1], 30274); check("b1_n1_im", got_im[1], 12540);
    check("b1_n2_re", got_re[2], 23170); check("b1_n2_im", got_im[2], 23170);
    check("b1_n3_re", got_re[3], 12540); check("b1_n3_im", got_im[3], 30274);
    check("b1_n4_re", got_re[4], 0);     check("b1_n4_im", got_im[4], 32767);
    tick();

    // bin=3 forward
    issue_start(3, 1'b0);
    collect("b3", 3, 1'b0, 1'b0, 1'b0, -1);
    check("b3_n1_re", got_re[1], 12540);  check("b3_n1_im", got_im[1], 30274);
    check("b3_n2_re", got_re[2], -23170); check("b3_n2_im", got_im[2], 23170);
    check("b3_n2_re_bits", got_re[2] & 32'hFFFF, 32'hA57E);
    check("b3_n5_re", got_re[5], 30274);  check("b3_n5_im", got_im[5], -12540);
    tick();

    // bin=1 inverse
    issue_start(1, 1'b1);
    collect("b1i", 1, 1'b1, 1'b0, 1'b0, -1);
    check("b1i_n1_re", got_re[1], 30274); check("b1i_n1_im", got_im[1], -12540);
    check("b1i_n4_re", got_re[4], 0);     check("b1i_n4_im", got_im[4], -32767);
    check("b1i_n4_im_bits", got_im[4] & 32'hFFFF, 32'h8001);
    tick();

    // bin=5 with a randomly stalling consumer
    issue_start(5, 1'b0);
    collect("b5r", 5, 1'b0, 1'b1, 1'b0, -1);
    check("b5r_beats", n_beats, 16);
    out_ready = 1'b1;
    tick();

    // bin=4 while start/bin=7/inverse are hammered mid-sweep, then a start
    // in the very cycle busy falls
    issue_start(4, 1'b0);
    collect("b4s", 4, 1'b0, 1'b0, 1'b1, -1);
    check("b4s_beats", n_beats, 16);
    check("b4s_idle",  int'(busy), 0);
    issue_start(2, 1'b0);
    collect("b2f", 2, 1'b0, 1'b0, 1'b0, -1);
    check("b2f_beats", n_beats, 16);
    check("b2f_first_valid", first_c, 3);
    tick();

    // reset at beat 6 of a bin=3 sweep
    issue_start(3, 1'b0);
    collect("b3a", 3, 1'b0, 1'b0, 1'b0, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_busy",  int'(busy), 0);
    check("mid_rst_re",    int'(out_re), 0);
    check("mid_rst_im",    int'(out_im), 0);
    check("mid_rst_idx",   int'(out_idx), 0);
    tick();
    check("post_rst_valid", int'(out_valid), 0);

    // clean bin=2 sweep after the reset
    issue_start(2, 1'b0);
    collect("b2", 2, 1'b0, 1'b0, 1'b0, -1);
    check("b2_beats", n_beats, 16);
    check("b2_n0_re", got_re[0], 32767);  check("b2_n0_im", got_im[0], 0);
    check("b2_n3_re", got_re[3], -23170); check("b2_n3_im", got_im[3], 23170);
    check("b2_n4_re", got_re[4], -32767); check("b2_n4_im", got_im[4], 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
